// File: rtl/dmem_host_pkg.sv
// Shared types and default parameter values for the data-memory host port.
package dmem_host_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    typedef logic [7:0] addr_t;

    localparam addr_t LOAD_BASE_DEFAULT   = 8'd0;
    localparam addr_t RES_BASE_DEFAULT    = 8'd64;
    localparam int    RES_LEN_DEFAULT     = 16;
    localparam int    RUN_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/dmem_host_wdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the LIMIT-th one.
module dmem_host_wdog
    import dmem_host_pkg::*;
#(
    parameter int LIMIT = RUN_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [31:0] count;

    // expired is combinational so the owner can leave RUN on the LIMIT-th cycle itself
    assign expired = enable && (count == 32'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= 32'd0;
        end else if (enable && !expired) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/dmem_host_port.sv
// Host port that loads a processor's data memory, runs it, then streams results back.
// Define DMEM_HOST_TIMEOUT_EN to add the RUN-phase watchdog and the sticky err flag.
module dmem_host_port
    import dmem_host_pkg::*;
#(
    parameter addr_t LOAD_BASE   = LOAD_BASE_DEFAULT,
    parameter addr_t RES_BASE    = RES_BASE_DEFAULT,
    parameter int    RES_LEN     = RES_LEN_DEFAULT,
    parameter int    RUN_TIMEOUT = RUN_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       core_hold,
    input  logic       core_done,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_last,
    output logic       busy,
    output logic       fin,
    output logic       err
);
    state_t     state;
    addr_t      addr;
    logic [7:0] cnt;
    logic       wdog_expired;

    assign ld_ready  = (state == LOAD);
    // NOTE: gated by reset so a reset landing mid-LOAD cannot slip a final write through.
    assign mem_we    = ld_ready && ld_valid && reset;
    assign mem_addr  = addr;
    assign mem_wdata = ld_ready ? ld_data : 8'd0;
    assign core_hold = (state != RUN) || !reset;
    assign rd_valid  = (state == DRAIN);
    assign rd_data   = rd_valid ? mem_rdata : 8'd0;
    assign rd_last   = rd_valid && ({1'b0, cnt} == 9'(RES_LEN - 1));
    assign busy      = (state != IDLE);

    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= 8'd0;
            cnt   <= 8'd0;
            fin   <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        addr  <= LOAD_BASE;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        addr <= addr + 8'd1;
                        if (ld_last) state <= RUN;
                    end
                end
                RUN: begin
                    if (core_done || wdog_expired) begin
                        state <= DRAIN;
                        addr  <= RES_BASE;
                        cnt   <= 8'd0;
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        addr <= addr + 8'd1;
                        cnt  <= cnt + 8'd1;
                        if (rd_last) begin
                            state <= IDLE;
                            fin   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_HOST_TIMEOUT_EN
    dmem_host_wdog #(
        .LIMIT(RUN_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != RUN),
        .enable (state == RUN),
        .expired(wdog_expired)
    );

    // A core_done arriving on the expiry cycle counts as a normal finish
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (state == RUN && wdog_expired && !core_done) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (RUN_TIMEOUT != 0);
    assign wdog_expired   = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_host_port.sv
// Self-checking bench for dmem_host_port: two instances (plain and wrapping address bases)
// share stimulus; a table-driven session, hand-written corner cases and random sessions.
module tb_dmem_host_port;

    localparam logic [7:0] LB_A = 8'd0;
    localparam logic [7:0] RB_A = 8'd64;
    localparam logic [7:0] LB_B = 8'd254;
    localparam logic [7:0] RB_B = 8'd255;
    localparam int         RES_LEN = 2;
    localparam int         TIMEOUT = 8;

    typedef struct packed {
        logic       start;
        logic       ld_valid;
        logic [7:0] ld_data;
        logic       ld_last;
        logic       core_done;
        logic       rd_ready;
        logic       busy;
        logic       ld_ready;
        logic       we;
        logic       hold;
        logic       rd_valid;
        logic       rd_last;
        logic       fin;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       core_done;
    logic       rd_ready;

    logic       ld_ready_a, mem_we_a, core_hold_a, rd_valid_a, rd_last_a, busy_a, fin_a, err_a;
    logic [7:0] mem_addr_a, mem_wdata_a, mem_rdata_a, rd_data_a;
    logic       ld_ready_b, mem_we_b, core_hold_b, rd_valid_b, rd_last_b, busy_b, fin_b, err_b;
    logic [7:0] mem_addr_b, mem_wdata_b, mem_rdata_b, rd_data_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_da, pre_db;

    logic [7:0] exp_mem_a [256];
    logic [7:0] exp_mem_b [256];
    int         wr_cnt;
    int         rd_cnt;
    logic       exp_err;
    int         n_checks;
    int         n_errors;

    dmem_host_port #(
        .LOAD_BASE(LB_A), .RES_BASE(RB_A), .RES_LEN(RES_LEN), .RUN_TIMEOUT(TIMEOUT)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_data(ld_data), .ld_last(ld_last),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata_a),
        .core_hold(core_hold_a), .core_done(core_done),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a), .rd_last(rd_last_a),
        .busy(busy_a), .fin(fin_a), .err(err_a)
    );

    dmem_host_port #(
        .LOAD_BASE(LB_B), .RES_BASE(RB_B), .RES_LEN(RES_LEN), .RUN_TIMEOUT(TIMEOUT)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_data(ld_data), .ld_last(ld_last),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b),
        .core_hold(core_hold_b), .core_done(core_done),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b), .rd_last(rd_last_b),
        .busy(busy_b), .fin(fin_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Data memories behind each port, with a side door for preloading result bytes
    assign mem_rdata_a = mem_a[mem_addr_a];
    assign mem_rdata_b = mem_b[mem_addr_b];
    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_da;
            mem_b[pre_addr] <= pre_db;
        end
        if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // in = {start, ld_valid, ld_last, core_done, rd_ready}; ex = {busy, ld_ready, we, hold, rd_valid, rd_last, fin}
    function automatic vec_t mk(input logic [4:0] in, input logic [7:0] d, input logic [6:0] ex);
        vec_t v;
        v.start = in[4]; v.ld_valid = in[3]; v.ld_last = in[2]; v.core_done = in[1]; v.rd_ready = in[0];
        v.ld_data = d;
        v.busy = ex[6]; v.ld_ready = ex[5]; v.we = ex[4]; v.hold = ex[3];
        v.rd_valid = ex[2]; v.rd_last = ex[1]; v.fin = ex[0];
        return v;
    endfunction

    task automatic chk_dut(input string tag, input vec_t v, input logic [7:0] xwa, input logic [7:0] xra,
                           input logic [7:0] xrd, input logic busy_g, input logic ldr_g, input logic we_g,
                           input logic hold_g, input logic rdv_g, input logic rdl_g, input logic fin_g,
                           input logic err_g, input logic [7:0] addr_g, input logic [7:0] wdata_g,
                           input logic [7:0] rdata_g);
        check_bit({tag, ".busy"}, busy_g, v.busy);
        check_bit({tag, ".ld_ready"}, ldr_g, v.ld_ready);
        check_bit({tag, ".mem_we"}, we_g, v.we);
        check_bit({tag, ".core_hold"}, hold_g, v.hold);
        check_bit({tag, ".rd_valid"}, rdv_g, v.rd_valid);
        check_bit({tag, ".rd_last"}, rdl_g, v.rd_last);
        check_bit({tag, ".fin"}, fin_g, v.fin);
        check_bit({tag, ".err"}, err_g, exp_err);
        if (v.we) begin
            check({tag, ".wr_addr"}, addr_g, xwa);
            check({tag, ".wr_data"}, wdata_g, v.ld_data);
        end
        if (v.rd_valid) begin
            check({tag, ".rd_addr"}, addr_g, xra);
            check({tag, ".rd_data"}, rdata_g, xrd);
        end
    endtask

    task automatic check_cycle(input vec_t v, input string tag);
        logic [7:0] wa_a, wa_b, ra_a, ra_b;
        if (v.start && !v.busy) begin
            wr_cnt = 0;
            rd_cnt = 0;
        end
        wa_a = LB_A + 8'(wr_cnt);
        wa_b = LB_B + 8'(wr_cnt);
        ra_a = RB_A + 8'(rd_cnt);
        ra_b = RB_B + 8'(rd_cnt);
        chk_dut({tag, "/a"}, v, wa_a, ra_a, exp_mem_a[ra_a], busy_a, ld_ready_a, mem_we_a, core_hold_a,
                rd_valid_a, rd_last_a, fin_a, err_a, mem_addr_a, mem_wdata_a, rd_data_a);
        chk_dut({tag, "/b"}, v, wa_b, ra_b, exp_mem_b[ra_b], busy_b, ld_ready_b, mem_we_b, core_hold_b,
                rd_valid_b, rd_last_b, fin_b, err_b, mem_addr_b, mem_wdata_b, rd_data_b);
        if (v.we) begin
            exp_mem_a[wa_a] = v.ld_data;
            exp_mem_b[wa_b] = v.ld_data;
            wr_cnt++;
        end
        if (v.rd_valid && v.rd_ready) rd_cnt++;
    endtask

    task automatic apply(input vec_t v, input string tag);
        start     = v.start;
        ld_valid  = v.ld_valid;
        ld_data   = v.ld_data;
        ld_last   = v.ld_last;
        core_done = v.core_done;
        rd_ready  = v.rd_ready;
        #2;
        check_cycle(v, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic pre_write(input logic [7:0] a, input logic [7:0] da, input logic [7:0] db);
        pre_we = 1'b1; pre_addr = a; pre_da = da; pre_db = db;
        exp_mem_a[a] = da;
        exp_mem_b[a] = db;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic do_start(input string tag);
        apply(mk(5'b10000, 8'h00, 7'b0001000), tag);
    endtask

    task automatic do_load(input int n, input string tag);
        int         idx;
        logic       vld, lst;
        logic [7:0] d;
        idx = 0;
        while (idx < n) begin
            vld = ($urandom_range(0, 3) != 0);
            lst = vld ? (idx == n - 1) : 1'($urandom);
            d   = 8'($urandom);
            apply(mk({1'($urandom), vld, lst, 1'($urandom), 1'($urandom)}, d, {3'b111 & {2'b11, vld}, 4'b1000}), tag);
            if (vld) idx++;
        end
    endtask

    task automatic do_run(input int k, input string tag);
        for (int i = 0; i < k; i++)
            apply(mk({1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom)}, 8'($urandom), 7'b1000000), tag);
        apply(mk({1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom)}, 8'($urandom), 7'b1000000), tag);
    endtask

    task automatic do_drain(input string tag);
        int   acc;
        logic rdy;
        acc = 0;
        while (acc < RES_LEN) begin
            rdy = 1'($urandom);
            apply(mk({1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rdy}, 8'($urandom),
                     {5'b10011, (acc == RES_LEN - 1), 1'b0}), tag);
            if (rdy) acc++;
        end
        apply(mk({1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)}, 8'($urandom), 7'b0001001),
              {tag, ".fin"});
        apply(mk(5'b00000, 8'h00, 7'b0001000), {tag, ".after"});
    endtask

    initial begin
        vec_t tbl [14];
        tbl[0]  = mk(5'b10000, 8'h00, 7'b0001000);  // start accepted
        tbl[1]  = mk(5'b01000, 8'h11, 7'b1111000);
        tbl[2]  = mk(5'b01011, 8'h22, 7'b1111000);  // core_done/rd_ready ignored in LOAD
        tbl[3]  = mk(5'b00100, 8'h00, 7'b1101000);  // ld_last without ld_valid ignored
        tbl[4]  = mk(5'b11000, 8'h33, 7'b1111000);  // start ignored
        tbl[5]  = mk(5'b01100, 8'h44, 7'b1111000);  // last beat
        tbl[6]  = mk(5'b11101, 8'h55, 7'b1000000);  // RUN: core released, stray inputs
        tbl[7]  = mk(5'b00010, 8'h00, 7'b1000000);  // core_done
        tbl[8]  = mk(5'b11000, 8'h66, 7'b1001100);  // DRAIN stalled, stray start/ld_valid
        tbl[9]  = mk(5'b00001, 8'h00, 7'b1001100);
        tbl[10] = mk(5'b00010, 8'h00, 7'b1001110);  // stalled on last beat
        tbl[11] = mk(5'b00001, 8'h00, 7'b1001110);
        tbl[12] = mk(5'b01000, 8'h77, 7'b0001001);  // fin pulse
        tbl[13] = mk(5'b00010, 8'h00, 7'b0001000);

        clk = 1'b0; reset = 1'b0;
        start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0; core_done = 1'b0; rd_ready = 1'b0;
        pre_we = 1'b0; pre_addr = 8'h00; pre_da = 8'h00; pre_db = 8'h00;
        n_checks = 0; n_errors = 0; wr_cnt = 0; rd_cnt = 0; exp_err = 1'b0;
        @(posedge clk);
        #1;
        for (int a = 0; a < 256; a++) pre_write(8'(a), 8'($urandom), 8'($urandom));

        // Reset state, with every input pushing against it
        apply(mk(5'b11111, 8'hAA, 7'b0001000), "reset");
        check("reset.mem_addr_a", mem_addr_a, 8'h00);
        check("reset.mem_addr_b", mem_addr_b, 8'h00);
        check("reset.mem_wdata_a", mem_wdata_a, 8'h00);
        check("reset.rd_data_a", rd_data_a, 8'h00);
        check("reset.rd_data_b", rd_data_b, 8'h00);
        start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; core_done = 1'b0; rd_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        pre_write(8'd64, 8'hA5, 8'h00);
        pre_write(8'd65, 8'h5A, 8'h00);
        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Reset in the middle of a load, then a clean reload from LOAD_BASE
        do_start("rst_mid.start");
        apply(mk(5'b01000, 8'hA1, 7'b1111000), "rst_mid.beat1");
        apply(mk(5'b01000, 8'hA2, 7'b1111000), "rst_mid.beat2");
        reset = 1'b0;
        apply(mk(5'b01000, 8'h99, 7'b1101000), "rst_mid.reset_cycle");
        reset = 1'b1;
        apply(mk(5'b01100, 8'h98, 7'b0001000), "rst_mid.after");
        do_start("rst_mid.restart");
        do_load(3, "rst_mid.reload");
        do_run(1, "rst_mid.run");
        do_drain("rst_mid.drain");

`ifdef DMEM_HOST_TIMEOUT_EN
        do_start("wdog.start");
        apply(mk(5'b01100, 8'hC3, 7'b1111000), "wdog.beat");
        for (int i = 0; i < TIMEOUT; i++) apply(mk(5'b00000, 8'h00, 7'b1000000), $sformatf("wdog.run%0d", i));
        exp_err = 1'b1;
        do_drain("wdog.drain");
        do_start("wdog.restart");
        exp_err = 1'b0;
        do_load(1, "wdog.reload");
        do_run(0, "wdog.run_ok");
        do_drain("wdog.drain_ok");
`else
        do_start("norun.start");
        apply(mk(5'b01100, 8'hC3, 7'b1111000), "norun.beat");
        for (int i = 0; i < 20; i++) apply(mk(5'b00000, 8'h00, 7'b1000000), $sformatf("norun.run%0d", i));
        do_run(0, "norun.done");
        do_drain("norun.drain");
`endif

        for (int s = 0; s < 40; s++) begin
            pre_write(RB_A, 8'($urandom), 8'($urandom));
            pre_write(RB_A + 8'd1, 8'($urandom), 8'($urandom));
            pre_write(RB_B, 8'($urandom), 8'($urandom));
            pre_write(RB_B + 8'd1, 8'($urandom), 8'($urandom));
            do_start($sformatf("rnd%0d.start", s));
            do_load($urandom_range(1, 6), $sformatf("rnd%0d.load", s));
            do_run($urandom_range(0, 5), $sformatf("rnd%0d.run", s));
            do_drain($sformatf("rnd%0d.drain", s));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_host_port.md
DMEM_HOST_PORT -- requirements
Module: dmem_host_port

Interface
REQ-001 Parameter LOAD_BASE, default 8'd0, sets the data-memory address of the first loaded byte.
REQ-002 Parameter RES_BASE, default 8'd64, sets the data-memory address of the first result byte read back.
REQ-003 Parameter RES_LEN, default 16, sets the result byte count; legal range 1..256.
REQ-004 Parameter RUN_TIMEOUT, default 4096, sets the watchdog limit in cycles; used only with DMEM_HOST_TIMEOUT_EN.
REQ-005 Port clk, input, 1: the single clock; all state on posedge.
REQ-006 Port reset, input, 1: synchronous, active-low reset.
REQ-007 Port start, input, 1: begins a load/run/drain session.
REQ-008 Ports ld_valid (input, 1), ld_ready (output, 1), ld_data (input, 8) and ld_last (input, 1): host load stream.
REQ-009 Ports mem_addr (output, 8), mem_wdata (output, 8), mem_we (output, 1) and mem_rdata (input, 8, combinational read): data-memory port.
REQ-010 Ports core_hold (output, 1, holds the processor in reset) and core_done (input, 1, processor done flag).
REQ-011 Ports rd_valid (output, 1), rd_ready (input, 1), rd_data (output, 8) and rd_last (output, 1): result stream.
REQ-012 Ports busy (output, 1, state != IDLE), fin (output, 1, one-cycle pulse on session end) and err (output, 1, sticky timeout flag).

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN and DRAIN.
REQ-014 IDLE: start=1 -> LOAD next cycle, with addr<=LOAD_BASE; start is ignored in every other state.
REQ-015 LOAD: ld_ready=1; on ld_valid&&ld_ready, mem_we=1 that same cycle, mem_addr=addr, mem_wdata=ld_data, then addr+1 mod 256 (wraps 255->0).
REQ-016 LOAD: an accepted beat with ld_last=1 -> RUN; a single-beat load is legal.
REQ-017 ld_ready=0 and mem_we=0 in every state except LOAD; ld_valid is ignored outside LOAD.
REQ-018 core_hold=0 only in RUN; core_hold=1 in all other states and during reset.
REQ-019 RUN: core_done=1 sampled -> DRAIN, with addr<=RES_BASE and cnt<=0; core_done is ignored outside RUN.
REQ-020 DRAIN: mem_addr=addr, rd_valid=1, rd_data=mem_rdata, rd_last=(cnt==RES_LEN-1).
REQ-021 DRAIN: rd_valid, rd_data and rd_last SHALL stay stable until rd_ready=1.
REQ-022 DRAIN: on rd_ready, addr+1 mod 256 and cnt+1; an accepted beat with rd_last=1 -> IDLE with fin=1 for exactly that transition cycle.
REQ-023 rd_valid=0 outside DRAIN; rd_ready is ignored outside DRAIN.
REQ-024 Handshake latency: zero-cycle accept on both streams, giving one beat per cycle sustained.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE from any state, including mid-LOAD or mid-DRAIN; an in-flight session is abandoned and no memory write occurs in that cycle.
REQ-026 Reset values: ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, rd_valid=0, rd_data=0 (driven gated), rd_last=0, busy=0, fin=0, err=0, addr=0, cnt=0.

Configuration
REQ-027 With DMEM_HOST_TIMEOUT_EN defined, a watchdog counts RUN cycles; reaching RUN_TIMEOUT without core_done SHALL set err=1 and move RUN -> DRAIN as if core_done had occurred.
REQ-028 err SHALL clear only on reset or on the next accepted start.
REQ-029 Without DMEM_HOST_TIMEOUT_EN, no watchdog logic exists, err is tied 0 and RUN waits indefinitely.

Structure
REQ-030 Package dmem_host_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DRAIN), the 8-bit address typedef and the default parameter constants.
REQ-031 The watchdog SHALL be the sub-module dmem_host_wdog (clear, enable, expired), instantiated only under DMEM_HOST_TIMEOUT_EN.

Verification
REQ-032 Reset, then start with 4 beats 0x11,0x22,0x33,0x44 (last on 0x44) -> mem_we at addresses 0..3 with matching data, core_hold drops the cycle after the last accept.
REQ-033 LOAD_BASE=8'd254, 3 beats -> writes at addresses 254, 255, 0.
REQ-034 core_done=1 with RES_BASE=64 and RES_LEN=2, memory[64]=0xA5 and memory[65]=0x5A, rd_ready toggling 0/1 -> rd_data 0xA5 then 0x5A, each held stable while stalled; rd_last on the 2nd beat; one fin pulse.
REQ-035 reset=0 asserted after the 2nd load beat -> next cycle busy=0, core_hold=1, ld_ready=0; a new start reloads from LOAD_BASE.
REQ-036 With DMEM_HOST_TIMEOUT_EN and RUN_TIMEOUT=8, core_done held 0 -> err=1 after 8 RUN cycles and DRAIN entered.
REQ-037 start pulses during RUN and ld_valid pulses during DRAIN -> no state change and no mem_we.
